// File: rtl/icache_refill.sv
// icache_refill: miss handler between the 4-way ICache and main memory.
// Captures the line address of a miss and reads the line from memory over a
// req/ack handshake. It retries on timeout, writes the line back into the
// cache and stalls the core until the demand line has been written.
// All outputs are driven straight from flops.
// Optional feature: define ICACHE_PREFETCH_EN for next-line prefetch after
// each demand refill.
module icache_refill #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cache_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    output logic              o_stall,
    output logic              o_refill_done,
    output logic              o_err,
    output logic              o_fetch,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned WAIT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRetry,
        StWrite,
        StDone,
        StErr
`ifdef ICACHE_PREFETCH_EN
        ,
        StPfReq,
        StPfWrite
`endif
    } state_e;

    // FSM and datapath state
    state_e              r_state, w_state;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_data, w_data;
    logic [WAIT_W-1:0]   r_wait, w_wait;
    logic [RETRY_W-1:0]  r_retry, w_retry;
`ifdef ICACHE_PREFETCH_EN
    logic                r_pf, w_pf;
    logic [ADDR_W-1:0]   r_pf_addr, w_pf_addr;
    logic                r_pend, w_pend;
`endif

    // Registered outputs and their next values
    logic                r_stall, w_stall;
    logic                r_refill_done, w_refill_done;
    logic                r_err, w_err;
    logic                r_fetch, w_fetch;
    logic [ADDR_W-1:0]   r_write_addr, w_write_addr;
    logic [DATA_W-1:0]   r_write_data, w_write_data;
    logic                r_mem_req, w_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;

    // Line address: the two byte-offset bits are forced to zero
    logic [ADDR_W-1:0]   w_miss_line;
    logic                w_unused;
    assign w_miss_line = {i_miss_addr[ADDR_W-1:2], 2'b00};
    assign w_unused    = ^i_miss_addr[1:0];

    // Next-state logic: handshake, timeout/retry and prefetch sequencing
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_data  = r_data;
        w_wait  = r_wait;
        w_retry = r_retry;
`ifdef ICACHE_PREFETCH_EN
        w_pf      = r_pf;
        w_pf_addr = r_pf_addr;
        w_pend    = r_pend;
        // A demand miss during prefetch is parked in r_addr; the demand line
        // is already written so r_addr is free until the prefetch finishes.
        if ((r_state == StPfReq || r_state == StPfWrite || (r_state == StRetry && r_pf))
            && i_cache_miss && !r_pend) begin
            w_pend = 1'b1;
            w_addr = w_miss_line;
        end
`endif
        case (r_state)
            StIdle: begin
                if (i_cache_miss) begin
                    w_addr  = w_miss_line;
                    w_wait  = '0;
                    w_retry = '0;
                    w_state = StReq;
                end
            end
            StReq: begin
                // Ack wins over a timeout landing in the same cycle
                if (i_mem_ack) begin
                    w_data  = i_mem_rdata;
                    w_state = StWrite;
                end else if (r_wait == WAIT_LAST) begin
                    w_wait = '0;
                    if (r_retry == RETRY_MAX) begin
                        w_state = StErr;
                    end else begin
                        w_retry = r_retry + 1'b1;
                        w_state = StRetry;
                    end
                end else begin
                    w_wait = r_wait + 1'b1;
                end
            end
            StRetry: begin
`ifdef ICACHE_PREFETCH_EN
                w_state = r_pf ? StPfReq : StReq;
`else
                w_state = StReq;
`endif
            end
            StWrite: begin
                w_state = StDone;
            end
            StDone: begin
`ifdef ICACHE_PREFETCH_EN
                w_pf_addr = r_addr + ADDR_W'(4);
                w_pf      = 1'b1;
                w_wait    = '0;
                w_retry   = '0;
                w_state   = StPfReq;
`else
                w_state = StIdle;
`endif
            end
            StErr: begin
                w_state = StErr;
            end
`ifdef ICACHE_PREFETCH_EN
            StPfReq: begin
                if (i_mem_ack) begin
                    w_data  = i_mem_rdata;
                    w_state = StPfWrite;
                end else if (r_wait == WAIT_LAST) begin
                    w_wait = '0;
                    if (r_retry == RETRY_MAX) begin
                        // Abandon the prefetch without flagging an error
                        w_pf    = 1'b0;
                        w_retry = '0;
                        if (w_pend) begin
                            w_pend  = 1'b0;
                            w_state = StReq;
                        end else begin
                            w_state = StIdle;
                        end
                    end else begin
                        w_retry = r_retry + 1'b1;
                        w_state = StRetry;
                    end
                end else begin
                    w_wait = r_wait + 1'b1;
                end
            end
            StPfWrite: begin
                w_pf    = 1'b0;
                w_wait  = '0;
                w_retry = '0;
                if (w_pend) begin
                    w_pend  = 1'b0;
                    w_state = StReq;
                end else begin
                    w_state = StIdle;
                end
            end
`endif
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        w_mem_req     = 1'b0;
        w_mem_addr    = r_mem_addr;
        w_fetch       = 1'b0;
        w_write_addr  = r_write_addr;
        w_write_data  = r_write_data;
        w_refill_done = (w_state == StDone);
        w_err         = (w_state == StErr);
        w_stall       = (w_state inside {StReq, StWrite, StErr});
`ifdef ICACHE_PREFETCH_EN
        w_stall = w_stall || (w_state == StRetry && !w_pf) || w_pend;
`else
        w_stall = w_stall || (w_state == StRetry);
`endif
        case (w_state)
            StReq: begin
                w_mem_req  = 1'b1;
                w_mem_addr = w_addr;
            end
            StWrite: begin
                w_fetch      = 1'b1;
                w_write_addr = w_addr;
                w_write_data = w_data;
            end
`ifdef ICACHE_PREFETCH_EN
            StPfReq: begin
                w_mem_req  = 1'b1;
                w_mem_addr = w_pf_addr;
            end
            StPfWrite: begin
                w_fetch      = 1'b1;
                w_write_addr = w_pf_addr;
                w_write_data = w_data;
            end
`endif
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_data  <= '0;
            r_wait  <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_wait  <= w_wait;
            r_retry <= w_retry;
        end
    end

`ifdef ICACHE_PREFETCH_EN
    // Prefetch address and pending-miss registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pf      <= 1'b0;
            r_pf_addr <= '0;
            r_pend    <= 1'b0;
        end else begin
            r_pf      <= w_pf;
            r_pf_addr <= w_pf_addr;
            r_pend    <= w_pend;
        end
    end
`endif

    // Output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall       <= 1'b0;
            r_refill_done <= 1'b0;
            r_err         <= 1'b0;
            r_fetch       <= 1'b0;
            r_write_addr  <= '0;
            r_write_data  <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
        end else begin
            r_stall       <= w_stall;
            r_refill_done <= w_refill_done;
            r_err         <= w_err;
            r_fetch       <= w_fetch;
            r_write_addr  <= w_write_addr;
            r_write_data  <= w_write_data;
            r_mem_req     <= w_mem_req;
            r_mem_addr    <= w_mem_addr;
        end
    end

    assign o_stall       = r_stall;
    assign o_refill_done = r_refill_done;
    assign o_err         = r_err;
    assign o_fetch       = r_fetch;
    assign o_write_addr  = r_write_addr;
    assign o_write_data  = r_write_data;
    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed bench for icache_refill. Expected cache writes
// are queued by the stimulus and checked by an independent fetch monitor.
// Define ICACHE_PREFETCH_EN to also exercise the next-line prefetch.
module tb_icache_refill;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } fetch_t;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cache_miss = 1'b0;
    logic [AW-1:0] i_miss_addr = '0;
    logic          i_mem_ack = 1'b0;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          o_stall, o_refill_done, o_err, o_fetch, o_mem_req;
    logic [AW-1:0] o_write_addr, o_mem_addr;
    logic [DW-1:0] o_write_data;

    int     checks   = 0;
    int     failures = 0;
    fetch_t exp_q[$];

    icache_refill #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(4),
        .MAX_RETRY  (3)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cache_miss (i_cache_miss),
        .i_miss_addr  (i_miss_addr),
        .o_stall      (o_stall),
        .o_refill_done(o_refill_done),
        .o_err        (o_err),
        .o_fetch      (o_fetch),
        .o_write_addr (o_write_addr),
        .o_write_data (o_write_data),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        fetch_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, o_mem_req}, 32'd0);
        chk({tag, "_fetch"}, {31'd0, o_fetch}, 32'd0);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
        chk({tag, "_refill_done"}, {31'd0, o_refill_done}, 32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!o_refill_done && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_refill_done_seen"}, {31'd0, o_refill_done}, 32'd1);
    endtask

    // Called in the cycle after refill_done; serves the background prefetch
    task automatic pf_drain(input logic [AW-1:0] a);
`ifdef ICACHE_PREFETCH_EN
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        pa = a + 20'd4;
        pd = 32'hA5A5_0000 ^ {12'd0, pa};
        push(pa, pd);
        chk("pf_mem_req", {31'd0, o_mem_req}, 32'd1);
        chk("pf_mem_addr", {12'd0, o_mem_addr}, {12'd0, pa});
        chk("pf_stall", {31'd0, o_stall}, 32'd0);
        i_mem_ack   = 1'b1;
        i_mem_rdata = pd;
        step();
        i_mem_ack = 1'b0;
        chk("pf_write_stall", {31'd0, o_stall}, 32'd0);
        step();
        step();
`else
        if (a == 20'hFFFFF) $display("note: unreachable prefetch address");
`endif
    endtask

    // Fetch monitor: every cache write must match the head of the queue
    always @(negedge i_clk) begin
        fetch_t e;
        if (!i_rst && o_fetch) begin
            chk("fetch_with_mem_req", {31'd0, o_mem_req}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_fetch", {12'd0, o_write_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {12'd0, o_write_addr}, {12'd0, e.addr});
                chk("write_data", o_write_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rises;
        logic prev;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk_all_zero("rst");
        i_rst = 1'b0;
        step();
        chk_all_zero("idle");

        // T1: immediate ack
        i_cache_miss = 1'b1;
        i_miss_addr  = 20'h00124;
        push(20'h00124, 32'hDEADBEEF);
        step();
        i_cache_miss = 1'b0;
        chk("t1_stall_req", {31'd0, o_stall}, 32'd1);
        chk("t1_mem_req", {31'd0, o_mem_req}, 32'd1);
        chk("t1_mem_addr", {12'd0, o_mem_addr}, 32'h00124);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hDEADBEEF;
        step();
        i_mem_ack = 1'b0;
        chk("t1_fetch", {31'd0, o_fetch}, 32'd1);
        chk("t1_stall_write", {31'd0, o_stall}, 32'd1);
        chk("t1_mem_req_low", {31'd0, o_mem_req}, 32'd0);
        step();
        chk("t1_refill_done", {31'd0, o_refill_done}, 32'd1);
        chk("t1_stall_done", {31'd0, o_stall}, 32'd0);
        step();
        chk("t1_done_pulse", {31'd0, o_refill_done}, 32'd0);
        pf_drain(20'h00124);

        // T2: late ack, second miss during REQ ignored
        i_cache_miss = 1'b1;
        i_miss_addr  = 20'h00A07;
        push(20'h00A04, 32'h11223344);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t2_mem_req", {31'd0, o_mem_req}, 32'd1);
            chk("t2_mem_addr", {12'd0, o_mem_addr}, 32'h00A04);
            i_cache_miss = (i == 1);
            i_miss_addr  = 20'h12340;
            step();
        end
        i_cache_miss = 1'b0;
        chk("t2_mem_addr_last", {12'd0, o_mem_addr}, 32'h00A04);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h11223344;
        step();
        i_mem_ack = 1'b0;
        chk("t2_fetch", {31'd0, o_fetch}, 32'd1);
        wait_done("t2", 4);
        step();
        pf_drain(20'h00A04);

        // T3: one timeout then ack
        i_cache_miss = 1'b1;
        i_miss_addr  = 20'h00500;
        push(20'h00500, 32'hCAFEF00D);
        step();
        i_cache_miss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_mem_req", {31'd0, o_mem_req}, 32'd1);
            step();
        end
        chk("t3_retry_gap", {31'd0, o_mem_req}, 32'd0);
        chk("t3_retry_stall", {31'd0, o_stall}, 32'd1);
        step();
        chk("t3_mem_req_again", {31'd0, o_mem_req}, 32'd1);
        chk("t3_mem_addr_again", {12'd0, o_mem_addr}, 32'h00500);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hCAFEF00D;
        step();
        i_mem_ack = 1'b0;
        step();
        chk("t3_refill_done", {31'd0, o_refill_done}, 32'd1);
        chk("t3_err", {31'd0, o_err}, 32'd0);
        step();
        pf_drain(20'h00500);

        // T4: no ack at all -> ERR after 4 attempts
        i_cache_miss = 1'b1;
        i_miss_addr  = 20'h00800;
        step();
        i_cache_miss = 1'b0;
        n     = 1;
        rises = 0;
        prev  = 1'b0;
        while (!o_err && n < 40) begin
            if (o_mem_req && !prev) rises++;
            prev = o_mem_req;
            step();
            n++;
        end
        chk("t4_err_cycle", n, 32'd20);
        chk("t4_attempts", rises, 32'd4);
        chk("t4_err", {31'd0, o_err}, 32'd1);
        chk("t4_stall", {31'd0, o_stall}, 32'd1);
        chk("t4_mem_req", {31'd0, o_mem_req}, 32'd0);
        repeat (3) step();
        chk("t4_err_sticky", {31'd0, o_err}, 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        chk_all_zero("t4_rst");
        @(posedge i_clk);
        #3;
        i_rst = 1'b0;
        step();
        i_cache_miss = 1'b1;
        i_miss_addr  = 20'h00902;
        push(20'h00900, 32'h0BADF00D);
        step();
        i_cache_miss = 1'b0;
        chk("t4_new_addr", {12'd0, o_mem_addr}, 32'h00900);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h0BADF00D;
        step();
        i_mem_ack = 1'b0;
        wait_done("t4", 4);
        chk("t4_err_cleared", {31'd0, o_err}, 32'd0);
        step();
        pf_drain(20'h00900);

        // T5: async reset mid-REQ, late ack ignored
        i_cache_miss = 1'b1;
        i_miss_addr  = 20'h00C00;
        step();
        i_cache_miss = 1'b0;
        step();
        chk("t5_mem_req_before", {31'd0, o_mem_req}, 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("t5_mem_req_async", {31'd0, o_mem_req}, 32'd0);
        chk("t5_stall_async", {31'd0, o_stall}, 32'd0);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h55555555;
        @(posedge i_clk);
        #3;
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_fetch", {31'd0, o_fetch}, 32'd0);
            chk("t5_no_req", {31'd0, o_mem_req}, 32'd0);
        end
        i_mem_ack = 1'b0;
        step();

`ifdef ICACHE_PREFETCH_EN
        // T6: wrap-around prefetch with a demand miss arriving during PF_REQ
        i_cache_miss = 1'b1;
        i_miss_addr  = 20'hFFFFC;
        push(20'hFFFFC, 32'h01010101);
        push(20'h00000, 32'h02020202);
        push(20'h00300, 32'h03030303);
        step();
        i_cache_miss = 1'b0;
        i_mem_ack    = 1'b1;
        i_mem_rdata  = 32'h01010101;
        step();
        i_mem_ack = 1'b0;
        step();
        chk("t6_refill_done", {31'd0, o_refill_done}, 32'd1);
        step();
        chk("t6_pf_req", {31'd0, o_mem_req}, 32'd1);
        chk("t6_pf_addr", {12'd0, o_mem_addr}, 32'h00000);
        chk("t6_pf_stall", {31'd0, o_stall}, 32'd0);
        i_cache_miss = 1'b1;
        i_miss_addr  = 20'h00300;
        step();
        i_cache_miss = 1'b0;
        chk("t6_pend_stall", {31'd0, o_stall}, 32'd1);
        chk("t6_pf_addr_held", {12'd0, o_mem_addr}, 32'h00000);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h02020202;
        step();
        i_mem_ack = 1'b0;
        chk("t6_pf_fetch", {31'd0, o_fetch}, 32'd1);
        chk("t6_pf_no_done", {31'd0, o_refill_done}, 32'd0);
        step();
        chk("t6_demand_req", {31'd0, o_mem_req}, 32'd1);
        chk("t6_demand_addr", {12'd0, o_mem_addr}, 32'h00300);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h03030303;
        step();
        i_mem_ack = 1'b0;
        wait_done("t6", 4);
        step();
        pf_drain(20'h00300);
`endif

        repeat (2) step();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
